// File: rtl/uart_frame_parser_if.sv
// ---------------------------------------------------------------------------
// uart_frame_parser_if
//
// Bundles the byte stream from the UART receiver and the parsed-frame outputs
// of uart_frame_parser.
//
// Parameter:
//   AW        payload address width; must equal $clog2(NUMBER) of the parser.
//
// Signals:
//   rx_valid  one-cycle strobe: rx_data holds a received byte
//   rx_data   received byte
//   rx_err    framing/parity error, qualified by rx_valid
//   busy      a frame is in progress
//   frm_start one-cycle pulse when a CMD byte is accepted
//   frm_cmd   latched CMD byte
//   frm_len   decoded payload length, 0..256
//   pl_valid  payload byte strobe
//   pl_data   payload byte
//   pl_addr   payload index within the frame
//   frm_done  one-cycle end-of-frame pulse (good or bad)
//   frm_ok    frame good, qualified by frm_done
//   frm_err   error class, qualified by frm_done
//
// Modports:
//   master    byte source and consumer of the parsed frame (UART side / bench)
//   slave     the parser itself
// ---------------------------------------------------------------------------
interface uart_frame_parser_if #(
  parameter int AW = 8
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_err;
  logic          busy;
  logic          frm_start;
  logic [7:0]    frm_cmd;
  logic [8:0]    frm_len;
  logic          pl_valid;
  logic [7:0]    pl_data;
  logic [AW-1:0] pl_addr;
  logic          frm_done;
  logic          frm_ok;
  logic [2:0]    frm_err;

  modport master (
    output rx_valid, rx_data, rx_err,
    input  busy, frm_start, frm_cmd, frm_len, pl_valid, pl_data, pl_addr,
    input  frm_done, frm_ok, frm_err
  );

  modport slave (
    input  rx_valid, rx_data, rx_err,
    output busy, frm_start, frm_cmd, frm_len, pl_valid, pl_data, pl_addr,
    output frm_done, frm_ok, frm_err
  );
endinterface

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
//
// Byte-level parser for the host UART command protocol.
// Frame: CMD, LEN, LEN payload bytes, SUM where
//   SUM = ~(CMD + LEN + payload bytes) mod 256.
// LEN = 0 means NUMBER bytes when NUMBER is 256, otherwise an empty payload.
// Payload is streamed out with its index; the consumer commits it only when
// frm_done arrives with frm_ok set. After a length or rx error the parser
// discards bytes until the line has been quiet for the inter-byte timeout.
//
// Parameters:
//   CLOCK       system clock frequency in Hz
//   BAUD        UART bit rate
//   RX_TIMEOUT  inter-byte timeout in 10-bit character times
//   NUMBER      maximum payload bytes, power of two in 4..256
//
// Ports:
//   inclk       system clock
//   reset       synchronous active-high reset
//   bus         uart_frame_parser_if.slave (byte input + parsed frame output)
//   stat_ok     good-frame counter, saturating   (UART_FRAME_STATS_EN only)
//   stat_bad    bad-frame counter, saturating    (UART_FRAME_STATS_EN only)
//
// Optional feature: define UART_FRAME_STATS_EN to add the frame statistics
// counters and their ports. Without it the parser is otherwise identical.
//
// frm_err codes: 0 none, 1 checksum, 2 timeout, 3 length, 4 rx_err.
// All outputs are registered and respond the cycle after the causing byte.
// ---------------------------------------------------------------------------
module uart_frame_parser #(
  parameter int CLOCK      = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int RX_TIMEOUT = 2,
  parameter int NUMBER     = 256
) (
  input  logic               inclk,
  input  logic               reset,
  uart_frame_parser_if.slave bus
`ifdef UART_FRAME_STATS_EN
  ,
  output logic [15:0]        stat_ok,
  output logic [15:0]        stat_bad
`endif
);

  // 64-bit intermediate so large CLOCK * RX_TIMEOUT products do not overflow.
  localparam longint TO_CYC_L = (longint'(RX_TIMEOUT) * 64'd10 * longint'(CLOCK))
                                / longint'(BAUD);
  localparam int     TO_CYC   = int'(TO_CYC_L);
  localparam int     AW       = $clog2(NUMBER);
  // The counter only has to hold 0..TO_CYC-1.
  localparam int     TW       = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
  localparam logic [8:0]    NUM9    = 9'(NUMBER);

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_SUM  = 3'd1;
  localparam logic [2:0] ERR_TO   = 3'd2;
  localparam logic [2:0] ERR_LEN  = 3'd3;
  localparam logic [2:0] ERR_RX   = 3'd4;

  if (NUMBER < 4 || NUMBER > 256 || (NUMBER & (NUMBER - 1)) != 0) begin : g_bad_number
    $error("uart_frame_parser: NUMBER must be a power of two in 4..256");
  end
  if (TO_CYC < 1) begin : g_bad_timeout
    $error("uart_frame_parser: timeout must be at least one clock cycle");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM,
    S_SKIP
  } state_t;

  // LEN byte 0 stands for 256 only when the buffer can actually hold 256.
  function automatic logic [8:0] decode_len(input logic [7:0] b);
    if (b == 8'd0) begin
      return (NUMBER == 256) ? 9'd256 : 9'd0;
    end
    return {1'b0, b};
  endfunction

  state_t        state;
  logic [7:0]    sum;
  logic [8:0]    cnt;
  logic [TW-1:0] to_cnt;
  logic [8:0]    len_dec;
  logic          to_hit;

  always_comb begin
    len_dec = decode_len(bus.rx_data);
    to_hit  = (to_cnt == TO_LAST);
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      state         <= S_IDLE;
      sum           <= 8'd0;
      cnt           <= 9'd0;
      to_cnt        <= '0;
      bus.busy      <= 1'b0;
      bus.frm_start <= 1'b0;
      bus.frm_cmd   <= 8'd0;
      bus.frm_len   <= 9'd0;
      bus.pl_valid  <= 1'b0;
      bus.pl_data   <= 8'd0;
      bus.pl_addr   <= '0;
      bus.frm_done  <= 1'b0;
      bus.frm_ok    <= 1'b0;
      bus.frm_err   <= ERR_NONE;
    end else begin
      // Pulses and done-qualified fields default low every cycle.
      bus.frm_start <= 1'b0;
      bus.pl_valid  <= 1'b0;
      bus.frm_done  <= 1'b0;
      bus.frm_ok    <= 1'b0;
      bus.frm_err   <= ERR_NONE;

      // Any byte restarts the timeout, so a byte arriving on the expiry cycle
      // wins over the timeout.
      if (bus.rx_valid || state == S_IDLE || to_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end

      case (state)
        S_IDLE: begin
          if (bus.rx_valid && !bus.rx_err) begin
            bus.frm_cmd   <= bus.rx_data;
            bus.frm_start <= 1'b1;
            bus.busy      <= 1'b1;
            sum           <= bus.rx_data;
            state         <= S_LEN;
          end
        end

        S_LEN: begin
          if (bus.rx_valid) begin
            if (bus.rx_err) begin
              bus.frm_done <= 1'b1;
              bus.frm_err  <= ERR_RX;
              state        <= S_SKIP;
            end else if (len_dec > NUM9) begin
              bus.frm_done <= 1'b1;
              bus.frm_err  <= ERR_LEN;
              state        <= S_SKIP;
            end else begin
              sum         <= sum + bus.rx_data;
              bus.frm_len <= len_dec;
              cnt         <= 9'd0;
              state       <= (len_dec == 9'd0) ? S_SUM : S_DATA;
            end
          end else if (to_hit) begin
            bus.frm_done <= 1'b1;
            bus.frm_err  <= ERR_TO;
            bus.busy     <= 1'b0;
            state        <= S_IDLE;
          end
        end

        S_DATA: begin
          if (bus.rx_valid) begin
            if (bus.rx_err) begin
              bus.frm_done <= 1'b1;
              bus.frm_err  <= ERR_RX;
              state        <= S_SKIP;
            end else begin
              bus.pl_valid <= 1'b1;
              bus.pl_data  <= bus.rx_data;
              bus.pl_addr  <= cnt[AW-1:0];
              cnt          <= cnt + 9'd1;
              sum          <= sum + bus.rx_data;
              // 9-bit count so a 256-byte frame terminates without wrapping.
              if (cnt + 9'd1 == bus.frm_len) begin
                state <= S_SUM;
              end
            end
          end else if (to_hit) begin
            bus.frm_done <= 1'b1;
            bus.frm_err  <= ERR_TO;
            bus.busy     <= 1'b0;
            state        <= S_IDLE;
          end
        end

        S_SUM: begin
          if (bus.rx_valid) begin
            bus.frm_done <= 1'b1;
            if (bus.rx_err) begin
              bus.frm_err <= ERR_RX;
              state       <= S_SKIP;
            end else begin
              if (bus.rx_data == ~sum) begin
                bus.frm_ok  <= 1'b1;
                bus.frm_err <= ERR_NONE;
              end else begin
                bus.frm_err <= ERR_SUM;
              end
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end
          end else if (to_hit) begin
            bus.frm_done <= 1'b1;
            bus.frm_err  <= ERR_TO;
            bus.busy     <= 1'b0;
            state        <= S_IDLE;
          end
        end

        // Drop everything until the line goes quiet, then resynchronise.
        S_SKIP: begin
          if (!bus.rx_valid && to_hit) begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_FRAME_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counts from the registered frm_done, so totals lag the pulse by a cycle.
  always_ff @(posedge inclk) begin
    if (reset) begin
      stat_ok  <= 16'd0;
      stat_bad <= 16'd0;
    end else if (bus.frm_done) begin
      if (bus.frm_ok) begin
        stat_ok <= sat_inc16(stat_ok);
      end else begin
        stat_bad <= sat_inc16(stat_bad);
      end
    end
  end
`endif

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Byte-level parser for the host UART command protocol. Frame format: CMD, LEN, LEN payload bytes, SUM. SUM = ~(CMD + LEN + all payload bytes) mod 256.
- Sits between the UART receiver and the command/flash-control logic in Top.
- Generalised successor of the fixed-format command handling: parametrised maximum payload, inter-byte timeout, LEN=0 meaning maximum length, and classified error reporting.
- Payload is streamed out with a write address. The consumer commits it only on frm_ok.

Parameters:
- CLOCK, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate in bit/s.
- RX_TIMEOUT, 2, inter-byte timeout measured in 10-bit character times.
- NUMBER, 256, maximum payload bytes; power of two, range 4..256.
- Derived localparam TO_CYC = RX_TIMEOUT*10*CLOCK/BAUD.
- Derived localparam AW = $clog2(NUMBER).

Ports:
- inclk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- rx_err  in  1  framing/parity error flag, qualified by rx_valid
- busy  out  1  a frame is in progress (state other than IDLE)
- frm_start  out  1  one-cycle pulse when the CMD byte is accepted
- frm_cmd  out  8  latched CMD byte, held until the next frm_start
- frm_len  out  9  decoded payload length, 0..256
- pl_valid  out  1  payload byte strobe
- pl_data  out  8  payload byte
- pl_addr  out  AW  payload index, starting at 0 each frame
- frm_done  out  1  one-cycle pulse at end of frame (good or bad)
- frm_ok  out  1  qualified by frm_done: frame is good
- frm_err  out  3  qualified by frm_done: 0 none, 1 checksum, 2 timeout, 3 length, 4 rx_err

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: every output 0; state IDLE; sum, byte counter and timeout counter 0. Reset mid-frame discards the frame with no frm_done.
- All outputs are registered. Each response appears the cycle after the rx_valid that causes it.
- IDLE:
  - rx_valid with rx_err=0: latch CMD, sum=CMD, pulse frm_start, go to LEN.
  - rx_valid with rx_err=1: ignored, stay IDLE.
- LEN:
  - Decode length: byte 0 with NUMBER==256 -> 256; byte 0 with NUMBER<256 -> 0 (valid, empty payload).
  - Length > NUMBER -> frm_done, frm_err=3, go to SKIP.
  - Otherwise: sum += byte, set frm_len. Go to DATA, or to SUM if the length is 0.
- DATA:
  - Each byte: pl_valid=1, pl_data=byte, pl_addr=count; then count+1 and sum += byte.
  - When count reaches frm_len -> SUM.
- SUM:
  - Byte == ~sum[7:0] -> frm_done, frm_ok=1, frm_err=0.
  - Otherwise -> frm_done, frm_err=1.
  - Go to IDLE in both cases.
- Sum arithmetic: 8-bit, wraps modulo 256. Byte counter is 9 bits, so a 256-byte frame does not wrap before the compare. pl_addr is count[AW-1:0].
- rx_valid with rx_err=1 in LEN, DATA or SUM -> frm_done, frm_err=4, go to SKIP.
- Timeout counter:
  - Cleared on every rx_valid; counts in every state except IDLE.
  - Reaching TO_CYC in LEN, DATA or SUM -> frm_done, frm_err=2, go to IDLE.
  - Reaching TO_CYC in SKIP -> go to IDLE silently.
  - rx_valid in the same cycle as expiry: the byte wins and the counter is cleared.
- SKIP: discards bytes, restarting the timeout on each one. This resynchronises after a bad frame.
- frm_done and pl_valid are never asserted in the same cycle.
- The CMD value is not interpreted; the downstream command decoder owns it.

Optional Feature:
- Macro: UART_FRAME_STATS_EN.
- Defined:
  - Adds ports stat_ok[15:0] and stat_bad[15:0], both outputs, reset to 0.
  - stat_ok increments on frm_done with frm_ok=1; stat_bad increments on frm_done with frm_ok=0.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- ADDR frame 41 04 01 00 00 04 B5: frm_start with frm_cmd=41, frm_len=4, pl_data 01,00,00,04 at pl_addr 0..3, then frm_done with frm_ok=1.
- WRDATA frame 4B 04 11 22 33 44 06: frm_ok=1. Same frame with SUM=07: frm_done, frm_err=1, frm_ok=0.
- NUMBER=256, LEN=00, 256 random bytes plus correct SUM: 256 pl_valid strobes, pl_addr 0..255, frm_len=256, frm_ok=1.
- NUMBER=64, frame 4B 41 ...: frm_err=3 on the LEN byte; trailing bytes produce no pl_valid; a valid frame sent after a gap > TO_CYC parses with frm_ok=1.
- Send 4B 04 AA BB then silence: frm_done with frm_err=2 exactly TO_CYC cycles after the last rx_valid; busy drops to 0.
- rx_err=1 on the 2nd payload byte: frm_err=4. Assert reset mid-DATA: no frm_done, all outputs 0. With UART_FRAME_STATS_EN defined: stat_ok and stat_bad match the expected totals.
